// File: rtl/spi_flash_arbiter.sv
// Round-robin sharing of one mode-0 SPI READ flash between instruction fetch and data reads.
// Define SPI_ARB_FAST_READ_EN to use opcode 0x0B with 8 dummy clocks before data.
module spi_flash_arbiter #(
    parameter int unsigned SCLK_DIV = 1,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic [15:0] dm_addr,
    output logic        dm_valid,
    output logic [7:0]  dm_rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_mosi_oe,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE
    } state_t;

`ifdef SPI_ARB_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = READ_CMD;
`endif

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCLK_DIV - 1);

    state_t      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [7:0]  dm_rdata_q, dm_rdata_d;

    logic        div_end;
    logic        pick_dm;
    logic [4:0]  data_last;

    assign div_end   = (div_q == DIV_MAX);
    assign data_last = owner_q ? 5'd7 : 5'd15;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        if_valid_d = if_valid_q;
        dm_valid_d = dm_valid_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        pick_dm    = 1'b0;
        if (ena) begin
            if_valid_d = 1'b0;
            dm_valid_d = 1'b0;
            div_d      = div_end ? '0 : div_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    div_d = '0;
                    if (if_req || dm_req) begin
                        // last_q = 1 means DM was granted last
                        pick_dm = dm_req && (!if_req || !last_q);
                        owner_d = pick_dm;
                        last_d  = pick_dm;
                        state_d = S_CMD;
                        bit_d   = 5'd7;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = OPCODE[7];
                        tx_d    = {OPCODE[6:0], 8'h00,
                                   pick_dm ? dm_addr : if_addr, 1'b0};
                    end
                end
                S_DONE: begin
                    if (div_end) begin
                        if (bit_q == 5'd0) begin
                            state_d = S_IDLE;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                end
                default: begin
                    if (div_end && !sclk_q) begin
                        sclk_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[14:0], spi_miso};
                        end
                    end else if (div_end) begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                        bit_d  = bit_q - 5'd1;
                        if (bit_q == 5'd0) begin
                            unique case (state_q)
                                S_CMD: begin
                                    state_d = S_ADDR;
                                    bit_d   = 5'd23;
                                end
                                S_ADDR: begin
`ifdef SPI_ARB_FAST_READ_EN
                                    state_d = S_DUMMY;
                                    bit_d   = 5'd7;
`else
                                    state_d = S_DATA;
                                    bit_d   = data_last;
`endif
                                end
                                S_DUMMY: begin
                                    state_d = S_DATA;
                                    bit_d   = data_last;
                                end
                                default: begin
                                    state_d = S_DONE;
                                    bit_d   = 5'd1;
                                    cs_n_d  = 1'b1;
                                    mosi_d  = 1'b0;
                                    if (owner_q) begin
                                        dm_valid_d = 1'b1;
                                        dm_rdata_d = rx_q[7:0];
                                    end else begin
                                        if_valid_d = 1'b1;
                                        if_rdata_d = rx_q;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
            busy_d = (state_d != S_IDLE);
            oe_d   = (state_d == S_CMD) || (state_d == S_ADDR)
                  || (state_d == S_DUMMY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_valid    = dm_valid_q;
    assign dm_rdata    = dm_rdata_q;
    assign busy        = busy_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_mosi_oe = oe_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: two instances (SCLK_DIV 1 and 2), flash model, cycle model.
// Honours SPI_ARB_FAST_READ_EN for header length and expected latencies.
module tb_spi_flash_arbiter;

    localparam int NI = 2;
`ifdef SPI_ARB_FAST_READ_EN
    localparam int         HDR = 40;
    localparam logic [7:0] OPC = 8'h0B;
    localparam int         FX  = 1;
`else
    localparam int         HDR = 32;
    localparam logic [7:0] OPC = 8'h03;
    localparam int         FX  = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic chk_on;
    int   total = 0;
    int   bad = 0;

    logic        ena      [NI];
    logic        if_req   [NI];
    logic        dm_req   [NI];
    logic [15:0] if_addr  [NI];
    logic [15:0] dm_addr  [NI];
    logic        if_valid [NI];
    logic        dm_valid [NI];
    logic [15:0] if_rdata [NI];
    logic [7:0]  dm_rdata [NI];
    logic        busy     [NI];
    logic        cs_n     [NI];
    logic        sclk     [NI];
    logic        mosi     [NI];
    logic        oe       [NI];
    logic        miso     [NI];
    logic [39:0] fl_hdr   [NI];

    always #5 clk = ~clk;

    spi_flash_arbiter #(.SCLK_DIV(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]),
        .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_addr(dm_addr[0]),
        .dm_valid(dm_valid[0]), .dm_rdata(dm_rdata[0]),
        .busy(busy[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]),
        .spi_mosi(mosi[0]), .spi_mosi_oe(oe[0]), .spi_miso(miso[0])
    );

    spi_flash_arbiter #(.SCLK_DIV(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]),
        .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_addr(dm_addr[1]),
        .dm_valid(dm_valid[1]), .dm_rdata(dm_rdata[1]),
        .busy(busy[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]),
        .spi_mosi(mosi[1]), .spi_mosi_oe(oe[1]), .spi_miso(miso[1])
    );

    function automatic logic [7:0] mem(input logic [16:0] a);
        case (a)
            17'h00123: return 8'hA5;
            17'h00124: return 8'h3C;
            17'h000FF: return 8'h7E;
            17'h10000: return 8'h5A;
            default:   return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h96;
        endcase
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int lat_of(input int i, input bit own_dm);
        return (HDR + (own_dm ? 8 : 16)) * 2 * div_of(i);
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, i, a, e, $time);
        end
    endtask

    // Flash: shifts MOSI on SCLK rise, drives MISO on SCLK fall.
    for (genvar g = 0; g < NI; g++) begin : g_flash
        int          cnt = 0;
        logic [39:0] sh = '0;
        logic [39:0] hdr = '0;
        logic [16:0] fa = '0;
        logic        mb = 1'b0;
        always @(posedge sclk[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                cnt <= 0;
                sh  <= '0;
            end else begin
                sh <= {sh[38:0], mosi[g]};
                if (cnt == HDR - 1) hdr <= {sh[38:0], mosi[g]};
                cnt <= cnt + 1;
            end
        end
        always @(negedge sclk[g] or negedge cs_n[g]) begin
            int idx;
            logic [7:0] by;
            if (!cs_n[g] && cnt >= HDR) begin
                idx = cnt - HDR;
                if (idx == 0) fa = {1'b0, sh[HDR-17 -: 16]};
                by = mem(fa + 17'(idx / 8));
                mb = by[7 - (idx % 8)];
            end else begin
                mb = 1'b0;
            end
        end
        assign miso[g]   = mb;
        assign fl_hdr[g] = hdr;
    end

    // Transaction-level model: t counts enabled cycles since the grant.
    bit          m_act  [NI];
    int          m_t    [NI];
    bit          m_own  [NI];
    bit          m_last [NI];
    logic [15:0] m_addr [NI];
    logic [15:0] m_ifd  [NI];
    logic [7:0]  m_dmd  [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_act[i] = 0; m_t[i] = 0; m_own[i] = 0; m_last[i] = 1;
                m_addr[i] = '0; m_ifd[i] = '0; m_dmd[i] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (ena[i]) begin
                    if (m_act[i]) begin
                        m_t[i]++;
                        if (m_t[i] == lat_of(i, m_own[i])) begin
                            if (m_own[i]) m_dmd[i] = mem({1'b0, m_addr[i]});
                            else m_ifd[i] = {mem({1'b0, m_addr[i]}),
                                             mem({1'b0, m_addr[i]} + 17'd1)};
                        end
                        if (m_t[i] == lat_of(i, m_own[i]) + 2 * div_of(i))
                            m_act[i] = 0;
                    end else if (if_req[i] || dm_req[i]) begin
                        m_own[i]  = dm_req[i] && (!if_req[i] || !m_last[i]);
                        m_last[i] = m_own[i];
                        m_act[i]  = 1;
                        m_t[i]    = 0;
                        m_addr[i] = m_own[i] ? dm_addr[i] : if_addr[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                int d, l, t, k;
                logic [31:0] hw;
                logic run, em;
                d   = div_of(i);
                l   = lat_of(i, m_own[i]);
                t   = m_t[i];
                run = m_act[i] && (t < l);
                k   = t / (2 * d);
                hw  = {OPC, 8'h00, m_addr[i]};
                em  = 1'b0;
                if (run && k < 32) em = hw[31 - k];
                chk("cs_n", i, cs_n[i], !run);
                chk("sclk", i, sclk[i], run && ((t / d) % 2 == 1));
                chk("mosi", i, mosi[i], em);
                chk("oe", i, oe[i], run && (k < HDR));
                chk("busy", i, busy[i], m_act[i]);
                chk("if_valid", i, if_valid[i], m_act[i] && t == l && !m_own[i]);
                chk("dm_valid", i, dm_valid[i], m_act[i] && t == l && m_own[i]);
                chk("if_rdata", i, if_rdata[i], m_ifd[i]);
                chk("dm_rdata", i, dm_rdata[i], m_dmd[i]);
            end
        end
    end

    task automatic run_txn(input int i, input bit dm, input logic [15:0] a,
                           input logic [15:0] ed, input int el,
                           input logic [39:0] eh, input int fz);
        int g, v, fcnt, wrong;
        g = -1; v = -1; fcnt = 0; wrong = 0;
        @(negedge clk);
        if (dm) begin dm_addr[i] = a; dm_req[i] = 1'b1; end
        else begin if_addr[i] = a; if_req[i] = 1'b1; end
        for (int n = 0; n < 3000 && v < 0; n++) begin
            @(negedge clk);
            if (g < 0 && !cs_n[i]) g = n;
            if (!ena[i]) begin
                fcnt++;
                if (fcnt == 20) ena[i] = 1'b1;
            end
            if (fz > 0 && g >= 0 && n - g == fz) ena[i] = 1'b0;
            if (dm ? dm_valid[i] : if_valid[i]) v = n;
            if (dm ? if_valid[i] : dm_valid[i]) wrong++;
        end
        if_req[i] = 1'b0;
        dm_req[i] = 1'b0;
        ena[i]    = 1'b1;
        chk("timeout", i, (v < 0), 0);
        chk("latency", i, v - g, el);
        chk("rdata", i, dm ? {8'h00, dm_rdata[i]} : if_rdata[i], ed);
        chk("other_valid", i, wrong, 0);
        chk("header", i, fl_hdr[i], eh);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int seq[4];
        int nv;
        rst_n  = 1'b1;
        chk_on = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ena[i] = 1'b1; if_req[i] = 1'b0; dm_req[i] = 1'b0;
            if_addr[i] = '0; dm_addr[i] = '0;
        end
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_cs_n", i, cs_n[i], 1);
            chk("rst_sclk", i, sclk[i], 0);
            chk("rst_oe", i, oe[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_valids", i, {if_valid[i], dm_valid[i]}, 0);
        end

        run_txn(0, 0, 16'h0123, 16'hA53C, FX ? 112 : 96,
                FX ? 40'h0B00012300 : 40'h0003000123, 0);
        run_txn(1, 1, 16'h00FF, 16'h007E, FX ? 192 : 160,
                FX ? 40'h0B0000FF00 : 40'h00030000FF, 0);
        run_txn(0, 0, 16'h0010, 16'h8687, FX ? 112 : 96,
                FX ? 40'h0B00001000 : 40'h0003000010, 0);
        run_txn(0, 0, 16'h0123, 16'hA53C, FX ? 132 : 116,
                FX ? 40'h0B00012300 : 40'h0003000123, 30);
        run_txn(1, 0, 16'hFFFF, 16'h965A, FX ? 224 : 192,
                FX ? 40'h0B00FFFF00 : 40'h000300FFFF, 0);
        run_txn(0, 1, 16'h0124, 16'h003C, FX ? 96 : 80,
                FX ? 40'h0B00012400 : 40'h0003000124, 0);

        // Both requests held from reset: strict alternation starting with IF.
        @(posedge clk);
        #3 rst_n = 1'b0;
        if_addr[0] = 16'h0123; dm_addr[0] = 16'h00FF;
        if_req[0] = 1'b1; dm_req[0] = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        nv = 0;
        for (int n = 0; n < 2000 && nv < 4; n++) begin
            @(negedge clk);
            if (if_valid[0]) begin seq[nv] = 0; nv++; end
            else if (dm_valid[0]) begin seq[nv] = 1; nv++; end
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        chk("rr_count", 0, nv, 4);
        chk("rr_0", 0, seq[0], 0);
        chk("rr_1", 0, seq[1], 1);
        chk("rr_2", 0, seq[2], 0);
        chk("rr_3", 0, seq[3], 1);
        repeat (8) @(negedge clk);

        // Async reset in the middle of the DATA phase.
        if_addr[0] = 16'h0040; if_req[0] = 1'b1;
        for (int n = 0; n < 50 && cs_n[0]; n++) @(negedge clk);
        repeat (80) @(negedge clk);
        chk("mid_busy", 0, busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 0, cs_n[0], 1);
        chk("arst_sclk", 0, sclk[0], 0);
        chk("arst_busy", 0, busy[0], 0);
        chk("arst_rdata", 0, if_rdata[0], 0);
        if_req[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
